// File: rtl/port4_serial_tx_ctrl_if.sv
// Handshake and data-path signals between the OUT 4 transmit sequencer and
// its surroundings (control unit on one side, out_port_4 on the other).
//   start     : request to transmit the current WBUS value
//   serial_in : bit 0 of port 4 (its serial_out)
//   Lo4       : load strobe to port 4
//   shift_r   : shift-right strobe to port 4
//   tx_line   : framed serial line, idles high
//   busy      : sequencer is inside a frame
//   done      : one-cycle pulse after the stop bit
//   bit_idx   : index of the data bit currently on tx_line
interface port4_serial_tx_ctrl_if;
    logic       start;
    logic       serial_in;
    logic       Lo4;
    logic       shift_r;
    logic       tx_line;
    logic       busy;
    logic       done;
    logic [2:0] bit_idx;

    modport master (
        output start, serial_in,
        input  Lo4, shift_r, tx_line, busy, done, bit_idx
    );

    modport slave (
        input  start, serial_in,
        output Lo4, shift_r, tx_line, busy, done, bit_idx
    );
endinterface

// File: rtl/port4_serial_tx_ctrl.sv
// Transmit sequencer for output port 4. One accepted start request loads
// port 4 from WBUS, then sends start bit, 8 data bits LSB-first (shifting
// port 4 once per bit) and a stop bit on tx_line, then pulses done.
// Ports:
//   CLK  : system clock, rising edge
//   CLR  : asynchronous active-high reset
//   bus  : slave side of port4_serial_tx_ctrl_if (see interface file)
//
// state | meaning
// IDLE  | line high, waiting for start (also the done cycle)
// LOAD  | one cycle, Lo4 high, port 4 captures WBUS at its closing edge
// START | BIT_CYCLES cycles of start bit (line low)
// DATA  | 8 bit periods, line follows serial_in, shift_r on last cycle of each
// STOP  | BIT_CYCLES cycles of stop bit (line high)
module port4_serial_tx_ctrl #(
    parameter int BIT_CYCLES = 4,
    parameter int DATA_BITS  = 8
) (
    input  logic                  CLK,
    input  logic                  CLR,
    port4_serial_tx_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    localparam logic [7:0] BAUD_TC  = 8'(BIT_CYCLES - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    // With one clock per bit every DATA cycle is a terminal-count cycle.
    localparam logic       SHIFT_EVERY = (BIT_CYCLES == 1);

    state_t     state_q;
    logic [7:0] baud_q;
    logic [2:0] bit_q;
    logic       lo4_q;
    logic       shift_q;
    logic       busy_q;
    logic       done_q;
    logic       tx_q;

    // Outputs are registered, so each branch sets them for the cycle that
    // follows the edge; shift_q therefore looks one count ahead.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            lo4_q   <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            lo4_q   <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= LOAD;
                        lo4_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q <= START;
                    baud_q  <= '0;
                    tx_q    <= 1'b0;
                end
                START: begin
                    if (baud_q == BAUD_TC) begin
                        state_q <= DATA;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        shift_q <= SHIFT_EVERY;
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end
                DATA: begin
                    if (baud_q == BAUD_TC) begin
                        baud_q <= '0;
                        if (bit_q == LAST_BIT) begin
                            state_q <= STOP;
                            bit_q   <= '0;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= SHIFT_EVERY;
                        end
                    end else begin
                        baud_q  <= baud_q + 8'd1;
                        shift_q <= ((baud_q + 8'd1) == BAUD_TC);
                    end
                end
                STOP: begin
                    if (baud_q == BAUD_TC) begin
                        state_q <= IDLE;
                        baud_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.Lo4     = lo4_q;
    assign bus.shift_r = shift_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bit_idx = bit_q;
    // Data bits come straight from port 4 so the line changes at the shift edge.
    assign bus.tx_line = (state_q == DATA) ? bus.serial_in : tx_q;
endmodule

// File: tb/tb_port4_serial_tx_ctrl.sv
module tb_port4_serial_tx_ctrl;
    logic CLK = 1'b0;
    logic CLR = 1'b0;
    logic clk_run = 1'b0;
    logic chk_en = 1'b0;

    always begin
        #5;
        if (clk_run) CLK = ~CLK;
    end

    port4_serial_tx_ctrl_if if4 ();
    port4_serial_tx_ctrl_if if1 ();

    port4_serial_tx_ctrl #(.BIT_CYCLES(4)) u4 (.CLK(CLK), .CLR(CLR), .bus(if4.slave));
    port4_serial_tx_ctrl #(.BIT_CYCLES(1)) u1 (.CLK(CLK), .CLR(CLR), .bus(if1.slave));

    // index 0 -> BIT_CYCLES=4 instance, index 1 -> BIT_CYCLES=1 instance
    logic       start_a [2];
    logic [7:0] wbus_a  [2];
    logic [7:0] port_q  [2] = '{8'h00, 8'h00};
    logic       lo4_a [2], shift_a [2], tx_a [2], busy_a [2], done_a [2];
    logic [2:0] bidx_a [2];

    assign if4.start     = start_a[0];
    assign if1.start     = start_a[1];
    assign if4.serial_in = port_q[0][0];
    assign if1.serial_in = port_q[1][0];
    assign lo4_a[0] = if4.Lo4;     assign lo4_a[1] = if1.Lo4;
    assign shift_a[0] = if4.shift_r; assign shift_a[1] = if1.shift_r;
    assign tx_a[0] = if4.tx_line;  assign tx_a[1] = if1.tx_line;
    assign busy_a[0] = if4.busy;   assign busy_a[1] = if1.busy;
    assign done_a[0] = if4.done;   assign done_a[1] = if1.done;
    assign bidx_a[0] = if4.bit_idx; assign bidx_a[1] = if1.bit_idx;

    // out_port_4 stand-in: load from WBUS, shift right with zero fill.
    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (lo4_a[i]) port_q[i] <= wbus_a[i];
            else if (shift_a[i]) port_q[i] <= {1'b0, port_q[i][7:1]};
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int bc(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Frame-level model: a frame is 1 + 10*BC cycles counted by position p.
    logic       m_busy [2];
    logic       m_done [2];
    int         m_pos  [2];
    logic [7:0] m_data [2];

    always @(posedge CLK or posedge CLR) begin
        for (int i = 0; i < 2; i++) begin
            if (CLR) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_pos[i]  <= 0;
            end else if (m_busy[i]) begin
                if (m_pos[i] == 0) m_data[i] <= wbus_a[i];
                if (m_pos[i] == 10 * bc(i)) begin
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                end else begin
                    m_pos[i] <= m_pos[i] + 1;
                end
            end else begin
                m_done[i] <= 1'b0;
                if (start_a[i]) begin
                    m_busy[i] <= 1'b1;
                    m_pos[i]  <= 0;
                end
            end
        end
    end

    logic q4_tx[$], q4_busy[$], q1_tx[$], q1_busy[$], q1_shift[$];
    int   c4_lo4, c4_shift, c4_done, c1_done;

    task automatic clr_rec();
        q4_tx = {}; q4_busy = {}; q1_tx = {}; q1_busy = {}; q1_shift = {};
        c4_lo4 = 0; c4_shift = 0; c4_done = 0; c1_done = 0;
    endtask

    always @(negedge CLK) begin : cmp
        int p, b, k;
        logic e_tx, e_lo4, e_sh, in_data;
        logic [2:0] e_bi;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                b = bc(i);
                p = m_pos[i];
                e_tx = 1'b1; e_lo4 = 1'b0; e_sh = 1'b0; e_bi = 3'd0; in_data = 1'b0;
                if (m_busy[i]) begin
                    in_data = (p >= b + 1) && (p <= 9 * b);
                    if (p == 0) e_lo4 = 1'b1;
                    else if (p <= b) e_tx = 1'b0;
                    else if (in_data) begin
                        k = (p - 1 - b) / b;
                        e_tx = m_data[i][k];
                        e_bi = 3'(k);
                        e_sh = ((p - b) % b) == 0;
                    end
                end
                chk($sformatf("bc%0d.tx_line p=%0d", b, p), tx_a[i], e_tx);
                chk($sformatf("bc%0d.Lo4 p=%0d", b, p), lo4_a[i], e_lo4);
                chk($sformatf("bc%0d.shift_r p=%0d", b, p), shift_a[i], e_sh);
                chk($sformatf("bc%0d.busy", b), busy_a[i], m_busy[i]);
                chk($sformatf("bc%0d.done", b), done_a[i], m_done[i]);
                chk($sformatf("bc%0d.bit_idx p=%0d", b, p), bidx_a[i], e_bi);
            end
            q4_tx.push_back(tx_a[0]); q4_busy.push_back(busy_a[0]);
            q1_tx.push_back(tx_a[1]); q1_busy.push_back(busy_a[1]); q1_shift.push_back(shift_a[1]);
            if (lo4_a[0]) c4_lo4++;
            if (shift_a[0]) c4_shift++;
            if (done_a[0]) c4_done++;
            if (done_a[1]) c1_done++;
        end
    end

    function automatic int busy_len4();
        int n = 0;
        foreach (q4_busy[i]) if (q4_busy[i]) n++;
        return n;
    endfunction

    // Data byte of frame f (BC=4), sampled mid-bit from busy cycles.
    function automatic int data_byte4(input int f);
        logic bt[$];
        int   r = 0;
        int   idx;
        foreach (q4_tx[i]) if (q4_busy[i]) bt.push_back(q4_tx[i]);
        for (int k = 0; k < 8; k++) begin
            idx = f * 41 + 5 + 4 * k + 2;
            if (idx >= bt.size()) return -1;
            if (bt[idx]) r = r | (1 << k);
        end
        return r;
    endfunction

    function automatic int frames4();
        int n = 0;
        logic prev = 1'b0;
        foreach (q4_busy[i]) begin
            if (q4_busy[i] && !prev) n++;
            prev = q4_busy[i];
        end
        return n;
    endfunction

    function automatic int gap4();
        int i = 0;
        int g = 0;
        while (i < q4_busy.size() && !q4_busy[i]) i++;
        while (i < q4_busy.size() && q4_busy[i]) i++;
        while (i < q4_busy.size() && !q4_busy[i]) begin g++; i++; end
        if (i >= q4_busy.size()) return -1;
        return g;
    endfunction

    task automatic check_idle_now(input string nm);
        for (int i = 0; i < 2; i++) begin
            chk({nm, ".tx_line"}, tx_a[i], 1);
            chk({nm, ".busy"}, busy_a[i], 0);
            chk({nm, ".Lo4"}, lo4_a[i], 0);
            chk({nm, ".shift_r"}, shift_a[i], 0);
            chk({nm, ".done"}, done_a[i], 0);
            chk({nm, ".bit_idx"}, bidx_a[i], 0);
        end
    endtask

    task automatic pulse_start(input int i, input logic [7:0] w);
        wbus_a[i] = w;
        start_a[i] = 1'b1;
        @(negedge CLK); #1;
        start_a[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int exp_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        int exp_u1[11] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        logic e_seq[$];
        logic bt[$];
        int nm, run, best;

        start_a[0] = 1'b0; start_a[1] = 1'b0;
        wbus_a[0] = 8'h00; wbus_a[1] = 8'h00;

        // Reset with the clock stopped: outputs must settle without an edge.
        #3 CLR = 1'b1;
        #1 check_idle_now("reset");
        chk_en = 1'b1;
        clk_run = 1'b1;
        repeat (2) @(negedge CLK); #1 CLR = 1'b0;
        repeat (2) @(negedge CLK); #1;

        // Single frame 0xA5
        clr_rec();
        pulse_start(0, 8'hA5);
        repeat (50) @(negedge CLK); #1;
        e_seq = {1'b1};
        repeat (4) e_seq.push_back(1'b0);
        for (int k = 0; k < 8; k++) repeat (4) e_seq.push_back(exp_a5[k][0]);
        repeat (4) e_seq.push_back(1'b1);
        bt = {};
        foreach (q4_tx[i]) if (q4_busy[i]) bt.push_back(q4_tx[i]);
        chk("t1.busy_cycles", bt.size(), 41);
        nm = 0;
        for (int i = 0; i < 41; i++) if (i >= bt.size() || bt[i] !== e_seq[i]) nm++;
        chk("t1.line_seq_errors", nm, 0);
        chk("t1.lo4_count", c4_lo4, 1);
        chk("t1.shift_count", c4_shift, 8);
        chk("t1.done_count", c4_done, 1);
        chk("t1.port4_end", port_q[0], 8'h00);

        // Start while busy (during data bit 3) is ignored
        clr_rec();
        pulse_start(0, 8'hA5);
        repeat (16) @(negedge CLK); #1;
        pulse_start(0, 8'hFF);
        repeat (40) @(negedge CLK); #1;
        chk("t2.lo4_count", c4_lo4, 1);
        chk("t2.data_byte", data_byte4(0), 8'hA5);
        chk("t2.done_count", c4_done, 1);
        chk("t2.frames", frames4(), 1);

        // Back-to-back with start held high
        clr_rec();
        wbus_a[0] = 8'h01;
        start_a[0] = 1'b1;
        repeat (2) @(negedge CLK); #1;
        wbus_a[0] = 8'h80;
        repeat (45) @(negedge CLK); #1;
        start_a[0] = 1'b0;
        repeat (45) @(negedge CLK); #1;
        chk("t3.frames", frames4(), 2);
        chk("t3.idle_gap", gap4(), 1);
        chk("t3.done_count", c4_done, 2);
        chk("t3.lo4_count", c4_lo4, 2);
        chk("t3.byte0", data_byte4(0), 8'h01);
        chk("t3.byte1", data_byte4(1), 8'h80);

        // Reset during data bit 5 (bit 5 of 0xC3 is 0, so the line must jump high)
        clr_rec();
        pulse_start(0, 8'hC3);
        repeat (25) @(negedge CLK); #1;
        chk("t4.pre_reset_line", tx_a[0], 0);
        #2 CLR = 1'b1;
        #1 check_idle_now("t4.abort");
        clr_rec();
        repeat (3) @(negedge CLK); #1;
        CLR = 1'b0;
        chk("t4.lo4_during_clr", c4_lo4, 0);
        chk("t4.shift_during_clr", c4_shift, 0);
        @(negedge CLK); #1;
        clr_rec();
        pulse_start(0, 8'h3C);
        repeat (50) @(negedge CLK); #1;
        chk("t4.busy_cycles", busy_len4(), 41);
        chk("t4.data_byte", data_byte4(0), 8'h3C);
        chk("t4.lo4_count", c4_lo4, 1);
        chk("t4.shift_count", c4_shift, 8);
        chk("t4.done_count", c4_done, 1);
        chk("t4.port4_end", port_q[0], 8'h00);

        // BIT_CYCLES=1, 0x55
        clr_rec();
        pulse_start(1, 8'h55);
        repeat (20) @(negedge CLK); #1;
        bt = {};
        foreach (q1_tx[i]) if (q1_busy[i]) bt.push_back(q1_tx[i]);
        chk("t5.busy_cycles", bt.size(), 11);
        nm = 0;
        for (int i = 0; i < 11; i++) if (i >= bt.size() || bt[i] !== exp_u1[i][0]) nm++;
        chk("t5.line_seq_errors", nm, 0);
        run = 0; best = 0;
        foreach (q1_shift[i]) begin
            run = q1_shift[i] ? run + 1 : 0;
            if (run > best) best = run;
        end
        chk("t5.shift_run", best, 8);
        chk("t5.done_count", c1_done, 1);
        chk("t5.port4_end", port_q[1], 8'h00);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/port4_serial_tx_ctrl.md
Name: port4_serial_tx_ctrl

Overview:
Sequencer for output port 4 that turns one "send" request into a framed asynchronous serial character on a single line.
- Pulses Lo4 so port 4 captures the accumulator value from WBUS.
- Emits a start bit, then the 8 data bits LSB-first, taken from port 4's serial_out. It pulses shift_r once per bit.
- Ends with a stop bit, then reports completion.
- Sits between the control unit (OUT 4 execution) and out_port_4.

Parameters:
BIT_CYCLES, 4, clocks per serial bit period; legal range 1..255.
DATA_BITS, 8, data bits per frame; fixed at 8 to match the port 4 width.

Ports:
CLK  input  1  system clock, all state updates on rising edge
CLR  input  1  asynchronous active-high reset
start  input  1  request to transmit current WBUS value; sampled only in IDLE
serial_in  input  1  port 4 bit 0 (out_port_4 serial_out)
Lo4  output  1  load strobe to port 4, one cycle per accepted request
shift_r  output  1  shift-right strobe to port 4, one cycle per data bit
tx_line  output  1  framed serial output; idle level 1
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse after the stop bit completes
bit_idx  output  3  index of the data bit currently on tx_line (0..7); 0 outside DATA

Behaviour:
- Reset is asynchronous. CLR high forces the following immediately and holds them while CLR is high:
  - state=IDLE, baud counter=0, bit counter=0;
  - Lo4=0, shift_r=0, done=0, busy=0, tx_line=1, bit_idx=0.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - tx_line=1.
  - start=1 at a rising edge moves to LOAD. Otherwise stay.
- LOAD (exactly 1 cycle):
  - Lo4=1; tx_line=1.
  - At the edge ending this cycle, port 4 captures WBUS.
  - Next state START; baud counter cleared.
- START (BIT_CYCLES cycles):
  - tx_line=0.
  - The baud counter counts 0..BIT_CYCLES-1. At the terminal count, go to DATA with bit counter=0.
- DATA (8 x BIT_CYCLES cycles):
  - tx_line=serial_in (combinational pass-through).
  - shift_r=1 only on the terminal-count cycle of each bit period, so the port advances to the next bit at the boundary edge.
  - At a terminal count with bit counter=7, go to STOP. Otherwise increment the bit counter.
  - Exactly 8 shift_r pulses per frame; the eighth leaves port 4 = 0x00.
- STOP (BIT_CYCLES cycles):
  - tx_line=1.
  - At the terminal count, return to IDLE and register done=1 for that first IDLE cycle.
- Outputs are Moore-decoded from state/counters except tx_line in DATA. Lo4 and shift_r are never high in the same cycle.
- busy=1 in LOAD, START, DATA and STOP.
- Latency and frame length:
  - start sampled at edge E puts LOAD in the cycle after E.
  - Frame = 1 + 10*BIT_CYCLES busy cycles.
  - done is high in the cycle after the last STOP cycle.
- Start handling:
  - start while busy is ignored; no queueing.
  - start in the done cycle (already IDLE) is accepted, giving back-to-back frames with 1 idle-high cycle between them.
  - start held high continuously produces repeated frames.
- BIT_CYCLES=1:
  - every DATA cycle asserts shift_r;
  - START and STOP are one cycle each.
- CLR asserted mid-frame: the frame aborts immediately with tx_line=1 and no further strobes. Port 4 contents are not restored.
- Counter widths: baud counter 8 bits; bit counter 3 bits. Neither wraps outside its state, because each is cleared on state entry.

Test Plan:
- Reset check: assert CLR mid-cycle with the clock stopped -> tx_line=1, busy=0, Lo4=0, shift_r=0, done=0 immediately.
- Single frame, BIT_CYCLES=4, bench instantiates out_port_4, WBUS=0xA5, start pulsed 1 cycle:
  - Lo4 high exactly 1 cycle;
  - tx_line = 1 (LOAD), 0x4, then 1,0,1,0,0,1,0,1 each x4, then 1x4;
  - 8 shift_r pulses; busy high 41 cycles; done 1 pulse; port 4 = 0x00 at end.
- Start while busy: pulse start again at DATA bit 3 with WBUS=0xFF -> no extra Lo4; the frame still carries 0xA5; exactly one done.
- Back-to-back: start held high, WBUS=0x01 then 0x80:
  - two frames with data bits 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1;
  - exactly 1 idle-high cycle between them; 2 done pulses.
- Mid-frame reset: CLR during DATA bit 5 -> tx_line=1 at once; no Lo4/shift_r while CLR is high; after release, start with 0x3C gives a clean full frame.
- BIT_CYCLES=1, WBUS=0x55:
  - frame of 11 busy cycles; tx_line = 1, 0, 1,0,1,0,1,0,1,0, 1;
  - shift_r high for 8 consecutive cycles.
